// File: rtl/multiword_add_sequencer_if.sv
// Operand, result and shared-adder signals of the multi-word add/sub sequencer.
// slave  : sequencer side (takes operands, drives the adder inputs, returns the result).
// master : environment side (issues operands, supplies the adder, consumes the result).
interface multiword_add_sequencer_if #(
    parameter int WORDS = 4
);
    localparam int N = 16 * WORDS;

    // Operand request
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  A;
    logic [N-1:0]  B;
    logic          sub;
    logic          cin;

    // Shared 16-bit adder (combinational, outside the sequencer)
    logic [15:0]   add_A;
    logic [15:0]   add_B;
    logic          add_cin;
    logic [15:0]   add_S;
    logic          add_cout;

    // Result
    logic [N-1:0]  S;
    logic          cout;
    logic          overflow;
    logic          out_valid;
    logic          out_ready;

    modport slave (
        input  in_valid, A, B, sub, cin,
        output in_ready,
        output add_A, add_B, add_cin,
        input  add_S, add_cout,
        output S, cout, overflow, out_valid,
        input  out_ready
    );

    modport master (
        output in_valid, A, B, sub, cin,
        input  in_ready,
        input  add_A, add_B, add_cin,
        output add_S, add_cout,
        input  S, cout, overflow, out_valid,
        output out_ready
    );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Purpose: WORDS*16-bit add/subtract by stepping one shared 16-bit adder, LSB slice first.
// Latency: accept at edge k -> out_valid after edge k+WORDS; accepts spaced >= WORDS+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
//
// Ports:
//   Clk      - rising-edge clock
//   Reset_n  - asynchronous active-low reset, discards any in-flight operation
//   bus      - slave modport: operand request (in_valid/in_ready, A, B, sub, cin),
//              shared adder (add_A/add_B/add_cin out, add_S/add_cout in),
//              result (S, cout, overflow, out_valid/out_ready)
module multiword_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    multiword_add_sequencer_if.slave    bus
);
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic [IDXW-1:0]         idx;
    logic                    carry;
    logic [WORDS-1:0][15:0]  a_reg;
    logic [WORDS-1:0][15:0]  b_reg;    // already inverted for subtraction
    logic [WORDS-1:0][15:0]  s_reg;
    logic                    cout_reg;
    logic                    ovf_reg;

    logic                    accept;
    logic                    last_slice;

    assign accept     = (state == IDLE) && bus.in_valid;
    assign last_slice = (idx == LAST_IDX);

    // Results come only from registers; nothing reaches S/cout/overflow straight from add_S.
    assign bus.S        = s_reg;
    assign bus.cout     = cout_reg;
    assign bus.overflow = ovf_reg;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake / adder-port outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.add_A     = '0;
        bus.add_B     = '0;
        bus.add_cin   = 1'b0;

        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                bus.add_A   = a_reg[idx];
                bus.add_B   = b_reg[idx];
                bus.add_cin = carry;
                if (last_slice) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                // Leaving DONE always passes through IDLE, so a new accept
                // can never coincide with the result handshake.
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, per-slice sum/carry, final flags
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            s_reg    <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            if (accept) begin
                a_reg <= bus.A;
                // A - B - bin == A + ~B + (1 - bin): invert B once here and
                // fold the borrow into the initial carry.
                b_reg <= bus.sub ? ~bus.B : bus.B;
                carry <= bus.cin ^ bus.sub;
                idx   <= '0;
                s_reg <= '0;
            end else if (state == RUN) begin
                s_reg[idx] <= bus.add_S;
                carry      <= bus.add_cout;
                if (last_slice) begin
                    cout_reg <= bus.add_cout;
                    // Sign of the top slice sum versus the common sign of the
                    // (effective) operands gives the N-bit signed overflow.
                    ovf_reg  <= (a_reg[WORDS-1][15] == b_reg[WORDS-1][15]) &&
                                (bus.add_S[15] != a_reg[WORDS-1][15]);
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Purpose: randomized and directed check of the add/sub sequencer (WORDS=4 and WORDS=1)
// Latency: drives one operation at a time, measures edges from accept to out_valid.
// Backpressure: holds out_ready low for a chosen number of cycles before consuming.
module tb_multiword_add_sequencer;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    multiword_add_sequencer_if #(.WORDS(4)) bus4 ();
    multiword_add_sequencer_if #(.WORDS(1)) bus1 ();

    multiword_add_sequencer #(.WORDS(4)) dut4 (.Clk(Clk), .Reset_n(Reset_n), .bus(bus4));
    multiword_add_sequencer #(.WORDS(1)) dut1 (.Clk(Clk), .Reset_n(Reset_n), .bus(bus1));

    // Behavioural 16-bit adders standing in for the shared external adder
    assign {bus4.add_cout, bus4.add_S} = {1'b0, bus4.add_A} + {1'b0, bus4.add_B} + 17'(bus4.add_cin);
    assign {bus1.add_cout, bus1.add_S} = {1'b0, bus1.add_A} + {1'b0, bus1.add_B} + 17'(bus1.add_cin);

    // Stimulus drivers; sel picks which DUT is exercised (0: WORDS=4, 1: WORDS=1)
    logic        sel = 1'b0;
    logic        drv_valid = 1'b0;
    logic        drv_ordy = 1'b0;
    logic [63:0] drv_a = '0;
    logic [63:0] drv_b = '0;
    logic        drv_sub = 1'b0;
    logic        drv_cin = 1'b0;

    assign bus4.in_valid  = drv_valid & ~sel;
    assign bus4.out_ready = drv_ordy & ~sel;
    assign bus4.A         = drv_a;
    assign bus4.B         = drv_b;
    assign bus4.sub       = drv_sub;
    assign bus4.cin       = drv_cin;
    assign bus1.in_valid  = drv_valid & sel;
    assign bus1.out_ready = drv_ordy & sel;
    assign bus1.A         = drv_a[15:0];
    assign bus1.B         = drv_b[15:0];
    assign bus1.sub       = drv_sub;
    assign bus1.cin       = drv_cin;

    // Observation of the selected DUT
    logic        o_in_ready, o_out_valid, o_cout, o_ovf, o_add_cin;
    logic [63:0] o_s;
    logic [15:0] o_add_a, o_add_b;
    assign o_in_ready  = sel ? bus1.in_ready  : bus4.in_ready;
    assign o_out_valid = sel ? bus1.out_valid : bus4.out_valid;
    assign o_cout      = sel ? bus1.cout      : bus4.cout;
    assign o_ovf       = sel ? bus1.overflow  : bus4.overflow;
    assign o_s         = sel ? 64'(bus1.S)    : bus4.S;
    assign o_add_a     = sel ? bus1.add_A     : bus4.add_A;
    assign o_add_b     = sel ? bus1.add_B     : bus4.add_B;
    assign o_add_cin   = sel ? bus1.add_cin   : bus4.add_cin;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-operand arithmetic on wide signed integers.
    // add: u = A + B + cin, cout = carry out of n bits
    // sub: u = A - B - bin, cout = 1 when no borrow (u >= 0)
    // overflow: signed result outside [-2^(n-1), 2^(n-1))
    task automatic ref_model(input int n, input logic [63:0] a, input logic [63:0] b,
                             input logic s, input logic c,
                             output logic [63:0] res, output logic co, output logic ov);
        logic signed [67:0] m, half, ua, ub, sa, sb, cc, u, sr;
        m    = 68'sd1 <<< n;
        half = m >>> 1;
        ua   = {4'b0, a};
        ub   = {4'b0, b};
        cc   = {67'b0, c};
        sa   = a[n-1] ? ua - m : ua;
        sb   = b[n-1] ? ub - m : ub;
        if (!s) begin
            u  = ua + ub + cc;
            sr = sa + sb + cc;
            co = (u >= m);
        end else begin
            u  = ua - ub - cc;
            sr = sa - sb - cc;
            co = (u >= 0);
        end
        res = 64'(u & (m - 68'sd1));
        ov  = (sr >= half) || (sr < -half);
    endtask

    // One complete operation: offer, accept, measure latency, check result,
    // optionally stall the consumer, then take the result.
    task automatic run_op(input bit use1, input logic [63:0] a, input logic [63:0] b,
                          input logic s, input logic c, input int hold, input bit keep_valid,
                          input logic [63:0] exp_s, input logic exp_co, input logic exp_ov);
        int lat;
        sel = use1;
        #0;
        check_val("in_ready_idle", 64'(o_in_ready), 64'd1);
        drv_a = a; drv_b = b; drv_sub = s; drv_cin = c;
        drv_valid = 1'b1;
        drv_ordy  = 1'b0;
        @(posedge Clk); #1;
        if (!keep_valid) drv_valid = 1'b0;
        check_val("in_ready_busy", 64'(o_in_ready), 64'd0);
        lat = 0;
        while (!o_out_valid && lat < 20) begin
            @(posedge Clk); #1;
            lat++;
        end
        check_val(use1 ? "latency_w1" : "latency_w4", 64'(lat), use1 ? 64'd1 : 64'd4);
        check_val("sum", o_s, exp_s);
        check_val("cout", 64'(o_cout), 64'(exp_co));
        check_val("overflow", 64'(o_ovf), 64'(exp_ov));
        for (int i = 0; i < hold; i++) begin
            @(posedge Clk); #1;
            check_val("hold_out_valid", 64'(o_out_valid), 64'd1);
            check_val("hold_sum", o_s, exp_s);
            check_val("hold_in_ready", 64'(o_in_ready), 64'd0);
        end
        drv_ordy = 1'b1;
        @(posedge Clk); #1;
        drv_ordy = 1'b0;
        check_val("out_valid_clear", 64'(o_out_valid), 64'd0);
    endtask

    task automatic rand_op(input bit use1);
        logic [63:0] a, b, r;
        logic        s, c, co, ov;
        int          n;
        n = use1 ? 16 : 64;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: a = '1;
            1: b = 64'h8000_0000_0000_0000 >> (64 - n);
            2: a = 64'h7FFF_FFFF_FFFF_FFFF >> (64 - n);
            default: ;
        endcase
        if (use1) begin
            a = a & 64'hFFFF;
            b = b & 64'hFFFF;
        end
        s = 1'($urandom_range(0, 1));
        c = 1'($urandom_range(0, 1));
        ref_model(n, a, b, s, c, r, co, ov);
        run_op(use1, a, b, s, c, $urandom_range(0, 2), 1'b0, r, co, ov);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] ra, rb;

        // Reset state
        #12;
        check_val("rst_out_valid", 64'(bus4.out_valid), 64'd0);
        check_val("rst_sum", bus4.S, 64'd0);
        check_val("rst_cout", 64'(bus4.cout), 64'd0);
        check_val("rst_overflow", 64'(bus4.overflow), 64'd0);
        check_val("rst_add_a", 64'(bus4.add_A), 64'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        // Carry ripples out of the low slice
        run_op(1'b0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b0,
               64'h0000_0000_0001_0000, 1'b0, 1'b0);
        // Carry through every slice
        run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b0,
               64'h0, 1'b1, 1'b0);
        // Subtraction with borrow out, and signed overflow on subtract
        run_op(1'b0, 64'h0, 64'd1, 1'b1, 1'b0, 0, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        run_op(1'b0, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 0, 1'b0,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        // Consumer stalls 5 cycles with a new request pending; then next op accepted
        run_op(1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 5, 1'b1,
               64'h2222_2222_2222_2211, 1'b0, 1'b0);
        run_op(1'b0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b0,
               64'h0000_0000_0001_0000, 1'b0, 1'b0);

        // Asynchronous reset in the middle of an operation (third slice presented)
        sel = 1'b0;
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        drv_a = ra; drv_b = rb; drv_sub = 1'b0; drv_cin = 1'b0;
        drv_valid = 1'b1;
        @(posedge Clk); #1;
        drv_valid = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        check_val("mid_slice2_a", 64'(o_add_a), 64'(ra[47:32]));
        Reset_n = 1'b0;
        #2;
        check_val("arst_out_valid", 64'(o_out_valid), 64'd0);
        check_val("arst_add_a", 64'(o_add_a), 64'd0);
        check_val("arst_add_b", 64'(o_add_b), 64'd0);
        check_val("arst_add_cin", 64'(o_add_cin), 64'd0);
        check_val("arst_sum", o_s, 64'd0);
        check_val("arst_cout", 64'(o_cout), 64'd0);
        check_val("arst_overflow", 64'(o_ovf), 64'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        run_op(1'b0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b0,
               64'h0000_0000_0001_0000, 1'b0, 1'b0);

        // Single-slice instance
        run_op(1'b1, 64'h7FFF, 64'd1, 1'b0, 1'b0, 0, 1'b0, 64'h8000, 1'b0, 1'b1);
        run_op(1'b1, 64'hFFFF, 64'd1, 1'b0, 1'b0, 1, 1'b0, 64'h0000, 1'b1, 1'b0);

        // Randomized operations against the reference
        for (int i = 0; i < 40; i++) rand_op(1'b0);
        for (int i = 0; i < 20; i++) rand_op(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
